// File: rtl/aging_meas_scheduler.sv
// Aging-measurement campaign sequencer: stress, settle, count warning pulses in a fixed window,
// then report the count as a 6-byte frame over a byte-wide valid/ready link.
module aging_meas_scheduler #(
    parameter int unsigned STRESS_CYCLES = 1000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 4096,
    parameter int unsigned TIMER_W       = 24,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       warning_pulse,
    output logic       stress_o,
    output logic       test_en_o,
    output logic       window_o,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    typedef enum logic [2:0] {StIdle, StStress, StSettle, StMeasure, StReport} state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TIMER_W-1:0]   timer_last;
    logic                 timer_done;
    logic [7:0]           seq_q, seq_d;
    logic [15:0]          count_q, count_d;
    logic                 sat_q, sat_d;
    logic [2:0]           idx_q, idx_d;
    logic                 handshake;
    logic                 last_byte;
    logic [7:0]           flags;
    logic [7:0]           chk;

    assign handshake  = (state_q == StReport) && tx_ready;
    assign last_byte  = (idx_q == 3'd5);
    assign flags      = {sat_q, 7'b0};
    assign chk        = seq_q ^ count_q[15:8] ^ count_q[7:0] ^ flags;
    assign timer_done = (timer_q == timer_last);

    always_comb begin
        timer_last = '0;
        unique case (state_q)
            StStress:  timer_last = TIMER_W'(STRESS_CYCLES - 1);
            StSettle:  timer_last = TIMER_W'(SETTLE_CYCLES - 1);
            StMeasure: timer_last = TIMER_W'(WINDOW_CYCLES - 1);
            default:   timer_last = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            seq_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            seq_q   <= seq_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            idx_q   <= idx_d;
        end
    end

    // Abort on enable low takes priority over phase expiry; REPORT never aborts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (enable) state_d = StStress;
            StStress:  if (!enable) state_d = StIdle; else if (timer_done) state_d = StSettle;
            StSettle:  if (!enable) state_d = StIdle; else if (timer_done) state_d = StMeasure;
            StMeasure: if (!enable) state_d = StIdle; else if (timer_done) state_d = StReport;
            StReport:  if (handshake && last_byte) state_d = enable ? StStress : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (state_d != state_q || state_q inside {StIdle, StReport}) begin
            timer_d = '0;
        end

        count_d = count_q;
        sat_d   = sat_q;
        if (state_q == StSettle && state_d == StMeasure) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (state_q == StMeasure && warning_pulse) begin
            if (count_q == 16'hFFFF) sat_d = 1'b1;
            else                     count_d = count_q + 16'd1;
        end

        idx_d = idx_q;
        seq_d = seq_q;
        if (handshake) begin
            idx_d = last_byte ? 3'd0 : idx_q + 3'd1;
            if (last_byte) seq_d = seq_q + 8'd1;
        end
    end

    always_comb begin
        stress_o  = 1'b0;
        test_en_o = 1'b0;
        window_o  = 1'b0;
        busy      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        unique case (state_q)
            StStress: begin
                stress_o  = 1'b1;
                test_en_o = 1'b1;
                busy      = 1'b1;
            end
            StSettle: begin
                test_en_o = 1'b1;
                busy      = 1'b1;
            end
            StMeasure: begin
                test_en_o = 1'b1;
                window_o  = 1'b1;
                busy      = 1'b1;
            end
            StReport: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                unique case (idx_q)
                    3'd0:    tx_data = HEADER;
                    3'd1:    tx_data = seq_q;
                    3'd2:    tx_data = count_q[15:8];
                    3'd3:    tx_data = count_q[7:0];
                    3'd4:    tx_data = flags;
                    3'd5:    tx_data = chk;
                    default: tx_data = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aging_meas_scheduler.sv
// Bench for aging_meas_scheduler: frame table, corner-case sequences, random traffic against a
// campaign-position model, and a saturating long-window instance.
module tb_aging_meas_scheduler;

    localparam int S = 4;
    localparam int T = 2;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, pulse, rdy;
    logic       stress_o, test_en_o, window_o, busy, tx_valid;
    logic [7:0] tx_data;

    aging_meas_scheduler #(
        .STRESS_CYCLES(S), .SETTLE_CYCLES(T), .WINDOW_CYCLES(W), .TIMER_W(24), .HEADER(8'hA5)
    ) dut (
        .clk(clk), .reset(rst), .enable(en), .warning_pulse(pulse),
        .stress_o(stress_o), .test_en_o(test_en_o), .window_o(window_o), .busy(busy),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy)
    );

    logic       b_rst, b_en, b_pulse, b_rdy;
    logic       b_stress, b_test_en, b_window, b_busy, b_tx_valid;
    logic [7:0] b_tx_data;

    aging_meas_scheduler #(
        .STRESS_CYCLES(S), .SETTLE_CYCLES(T), .WINDOW_CYCLES(70000), .TIMER_W(24), .HEADER(8'hA5)
    ) dut_big (
        .clk(clk), .reset(b_rst), .enable(b_en), .warning_pulse(b_pulse),
        .stress_o(b_stress), .test_en_o(b_test_en), .window_o(b_window), .busy(b_busy),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_rdy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: position within a campaign since STRESS entry; phases follow from plain arithmetic.
    bit         m_active = 0;
    int         m_pos = 0;
    int         m_idx = 0;
    int         m_seq = 0;
    int         m_n = 0;
    logic [7:0] m_frame [6];

    function automatic bit m_report();
        return m_active && m_pos >= S + T + W;
    endfunction

    function automatic bit m_in_window();
        return m_active && m_pos >= S + T && m_pos < S + T + W;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic p, input logic y);
        int         cnt;
        logic [7:0] fl;
        if (r) begin
            m_active = 0; m_pos = 0; m_idx = 0; m_seq = 0; m_n = 0;
        end else if (!m_active) begin
            if (e) begin m_active = 1; m_pos = 0; end
        end else if (!m_report()) begin
            if (!e) begin
                m_active = 0;
            end else begin
                if (m_pos == S + T - 1) m_n = 0;
                if (m_in_window() && p) m_n++;
                m_pos++;
                if (m_pos == S + T + W) begin
                    cnt = (m_n > 65535) ? 65535 : m_n;
                    fl  = (m_n > 65535) ? 8'h80 : 8'h00;
                    m_frame[0] = 8'hA5;
                    m_frame[1] = 8'(m_seq);
                    m_frame[2] = 8'(cnt >> 8);
                    m_frame[3] = 8'(cnt);
                    m_frame[4] = fl;
                    m_frame[5] = m_frame[1] ^ m_frame[2] ^ m_frame[3] ^ fl;
                    m_idx = 0;
                end
            end
        end else if (y) begin
            if (m_idx == 5) begin
                m_seq = (m_seq + 1) % 256;
                m_idx = 0; m_pos = 0; m_active = e;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic check_model();
        logic [12:0] exp, act;
        exp = {m_active && m_pos < S, m_active && m_pos < S + T + W, m_in_window(), m_active,
               m_report(), m_report() ? m_frame[m_idx] : 8'h00};
        act = {stress_o, test_en_o, window_o, busy, tx_valid, tx_valid ? tx_data : 8'h00};
        chk("cycle", 64'(act), 64'(exp));
    endtask

    logic [7:0] cap[$];
    int n_stress, n_window;

    // Called at negedge: drive inputs, sample current-cycle outputs, clock, step model, check.
    task automatic step(input logic r, input logic e, input logic p, input logic y);
        rst = r; en = e; pulse = p; rdy = y;
        if (tx_valid && y && !r) cap.push_back(tx_data);
        n_stress += int'(stress_o);
        n_window += int'(window_o);
        @(posedge clk);
        model_update(r, e, p, y);
        @(negedge clk);
        check_model();
    endtask

    task automatic run_campaign(input logic settle_p, input logic [7:0] mask, input logic rand_rdy,
                                input logic drop_in_report, input int rst_at,
                                output logic [47:0] got);
        logic e, p, y;
        int   k;
        e = 1'b1;
        cap.delete();
        n_stress = 0;
        n_window = 0;
        got = '0;
        for (k = 0; k < 300 && cap.size() < 6; k++) begin
            p = 1'b0;
            if (m_active && m_pos >= S && m_pos < S + T) p = settle_p;
            if (m_in_window()) p = mask[m_pos - S - T];
            if (drop_in_report && tx_valid) e = 1'b0;
            y = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && cap.size() == rst_at) begin
                step(1'b1, 1'b0, 1'b0, 1'b1);
                return;
            end
            step(1'b0, e, p, y);
        end
        if (cap.size() < 6) begin
            fails++; tests++;
            $display("FAIL campaign_timeout: got %0d bytes required 6", cap.size());
        end
        foreach (cap[i]) got = {got[39:0], cap[i]};
    endtask

    typedef struct {
        logic        settle_p;
        logic [7:0]  mask;
        logic        rand_rdy;
        logic [47:0] frame;
    } vec_t;

    vec_t        tbl [5];
    logic [47:0] got;
    logic        e_r;
    bit          seen;
    int          k;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b0, 48'hA5_00_00_00_00_00};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 48'hA5_01_00_00_00_01};
        tbl[2] = '{1'b1, 8'h85, 1'b0, 48'hA5_02_00_03_00_01};
        tbl[3] = '{1'b0, 8'hFF, 1'b1, 48'hA5_03_00_08_00_0B};
        tbl[4] = '{1'b1, 8'h01, 1'b0, 48'hA5_04_00_01_00_05};

        rst = 1'b1; en = 1'b0; pulse = 1'b0; rdy = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_pulse = 1'b0; b_rdy = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reset_outputs", 64'({stress_o, test_en_o, window_o, busy, tx_valid, tx_data}), 64'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            run_campaign(tbl[i].settle_p, tbl[i].mask, tbl[i].rand_rdy, 1'b0, -1, got);
            chk($sformatf("frame%0d", i), 64'(got), 64'(tbl[i].frame));
            chk($sformatf("stress_len%0d", i), 64'(n_stress), 64'(S));
            chk($sformatf("window_len%0d", i), 64'(n_window), 64'(W));
        end

        // Abort mid-MEASURE: no frame, seq kept.
        for (k = 0; k < 50 && !window_o; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_idle", 64'({stress_o, test_en_o, window_o, busy}), 64'h0);
        seen = 0;
        for (k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            seen |= tx_valid;
        end
        chk("abort_no_valid", 64'(seen), 64'h0);
        run_campaign(1'b0, 8'h00, 1'b0, 1'b0, -1, got);
        chk("frame_after_abort", 64'(got), 64'hA5_05_00_00_00_05);

        // enable dropped during REPORT: frame completes, then idle.
        run_campaign(1'b0, 8'h02, 1'b1, 1'b1, -1, got);
        chk("frame_drop_in_report", 64'(got), 64'hA5_06_00_01_00_07);
        chk("idle_after_report", 64'({busy, tx_valid}), 64'h0);

        // Reset while byte 3 is presented, then a fresh frame.
        run_campaign(1'b0, 8'h00, 1'b0, 1'b0, 3, got);
        chk("reset_mid_frame",
            64'({stress_o, test_en_o, window_o, busy, tx_valid, tx_data}), 64'h0);
        run_campaign(1'b0, 8'h00, 1'b0, 1'b0, -1, got);
        chk("frame_after_reset", 64'(got), 64'hA5_00_00_00_00_00);

        // Random traffic checked cycle by cycle against the model.
        e_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) e_r = ~e_r;
            step(1'($urandom_range(0, 499) == 0), e_r, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        end

        // Long window with pulses every cycle: count saturates and sat is set.
        b_rst = 1'b0; b_en = 1'b1; b_pulse = 1'b1; b_rdy = 1'b1;
        for (k = 0; k < 71000 && !b_tx_valid; k++) @(negedge clk);
        b_en = 1'b0;
        chk("sat_valid_seen", 64'(b_tx_valid), 64'h1);
        got = '0;
        seen = 0;
        for (k = 0; k < 12 && b_tx_valid; k++) begin
            got = {got[39:0], b_tx_data};
            @(negedge clk);
        end
        chk("sat_frame", 64'(got), 64'hA5_00_FF_FF_80_80);
        chk("sat_idle", 64'({b_busy, b_tx_valid}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
